// File: rtl/pc_fetch_stage_pkg.sv
// Shared CPU constants and fetch-stage types.
package pc_fetch_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 5;

    localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_3000;
    localparam logic [XLEN-1:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [XLEN-1:0] IMEM_LO    = 32'h0000_3000;
    localparam logic [XLEN-1:0] IMEM_HI    = 32'h0000_6FFC;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

    // Payload carried from F into the F/D register.
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  ins;
        logic [EXC_W-1:0] exc;
        logic             bd;
    } fd_t;

    // Fetch address error: misaligned or outside the instruction window.
    function automatic logic fetch_fault(input logic [XLEN-1:0] pc,
                                         input logic [XLEN-1:0] lo,
                                         input logic [XLEN-1:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/f_d_reg.sv
// F/D pipeline register with hold (en low) and flush-to-bubble.
module f_d_reg #(
    parameter logic [31:0] RESET_PC = pc_fetch_stage_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic [31:0] pc_in,
    input  logic [31:0] ins_in,
    input  logic [4:0]  exc_in,
    input  logic        bd_in,
    output logic [31:0] pc,
    output logic [31:0] ins,
    output logic [4:0]  exc,
    output logic        bd
);
    import pc_fetch_stage_pkg::*;

    // Flush beats hold: a redirect always inserts a bubble tagged with the new PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc  <= RESET_PC;
            ins <= '0;
            exc <= EXC_NONE;
            bd  <= 1'b0;
        end else if (flush) begin
            pc  <= flush_pc;
            ins <= '0;
            exc <= EXC_NONE;
            bd  <= 1'b0;
        end else if (en) begin
            pc  <= pc_in;
            ins <= ins_in;
            exc <= exc_in;
            bd  <= bd_in;
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, fetch-fault detection and the F/D register.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC   = pc_fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] HANDLER_PC = pc_fetch_stage_pkg::HANDLER_PC,
    parameter logic [31:0] IMEM_LO    = pc_fetch_stage_pkg::IMEM_LO,
    parameter logic [31:0] IMEM_HI    = pc_fetch_stage_pkg::IMEM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] EPC,
    input  logic [31:0] NAddr,
    input  logic        D_IsBranch,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_PCPlus4,
    output logic [31:0] D_PC,
    output logic [31:0] D_Ins,
    output logic [4:0]  D_ExcCode,
    output logic        D_BD
);
    import pc_fetch_stage_pkg::*;

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        fault;
    logic        flush;
    logic [31:0] flush_pc;
    fd_t         f_stage;

    // F-stage payload; a faulting fetch becomes a nop carrying AdEL.
    always_comb begin
        fault   = fetch_fault(pc_q, IMEM_LO, IMEM_HI);
        f_stage = '{pc:  pc_q,
                    ins: fault ? 32'h0 : i_inst_rdata,
                    exc: fault ? EXC_ADEL : EXC_NONE,
                    bd:  D_IsBranch};
    end

    // Redirect selection and next PC: req > eret > stall > normal.
    always_comb begin
        flush    = req | eret;
        flush_pc = req ? HANDLER_PC : EPC;
        pc_next  = pc_q;
        if (req)        pc_next = HANDLER_PC;
        else if (eret)  pc_next = EPC;
        else if (!stall) pc_next = NAddr;
    end

    // PC register; any NAddr is accepted, faults surface only when fetched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_next;
    end

    assign F_PC        = pc_q;
    assign i_inst_addr = pc_q;
    assign F_PCPlus4   = pc_q + 32'd4;

    f_d_reg #(
        .RESET_PC (RESET_PC)
    ) u_f_d_reg (
        .clk      (clk),
        .reset    (reset),
        .en       (~stall),
        .flush    (flush),
        .flush_pc (flush_pc),
        .pc_in    (f_stage.pc),
        .ins_in   (f_stage.ins),
        .exc_in   (f_stage.exc),
        .bd_in    (f_stage.bd),
        .pc       (D_PC),
        .ins      (D_Ins),
        .exc      (D_ExcCode),
        .bd       (D_BD)
    );

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage.
`timescale 1ns/1ps
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] EPC;
    logic [31:0] NAddr;
    logic        D_IsBranch;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] F_PC;
    logic [31:0] F_PCPlus4;
    logic [31:0] D_PC;
    logic [31:0] D_Ins;
    logic [4:0]  D_ExcCode;
    logic        D_BD;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Instruction memory model: a distinct word per address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    assign i_inst_rdata = imem(i_inst_addr);

    pc_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .req          (req),
        .eret         (eret),
        .EPC          (EPC),
        .NAddr        (NAddr),
        .D_IsBranch   (D_IsBranch),
        .i_inst_addr  (i_inst_addr),
        .i_inst_rdata (i_inst_rdata),
        .F_PC         (F_PC),
        .F_PCPlus4    (F_PCPlus4),
        .D_PC         (D_PC),
        .D_Ins        (D_Ins),
        .D_ExcCode    (D_ExcCode),
        .D_BD         (D_BD)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; req = 1'b0; eret = 1'b0;
        EPC = 32'h0; NAddr = 32'h3004; D_IsBranch = 1'b0;
        #3;
        tests++; if (F_PC !== 32'h3000) begin fails++; $display("FAIL reset_f_pc got %h exp %h", F_PC, 32'h3000); end
        tests++; if (i_inst_addr !== 32'h3000) begin fails++; $display("FAIL reset_iaddr got %h exp %h", i_inst_addr, 32'h3000); end
        tests++; if (F_PCPlus4 !== 32'h3004) begin fails++; $display("FAIL reset_pcplus4 got %h exp %h", F_PCPlus4, 32'h3004); end
        tests++; if (D_PC !== 32'h3000) begin fails++; $display("FAIL reset_d_pc got %h exp %h", D_PC, 32'h3000); end
        tests++; if ({D_Ins, D_ExcCode, D_BD} !== 38'h0) begin fails++; $display("FAIL reset_d_fields got %h/%h/%b exp 0", D_Ins, D_ExcCode, D_BD); end
        tick(); tick();
        tests++; if (F_PC !== 32'h3000 || D_PC !== 32'h3000) begin fails++; $display("FAIL reset_held got %h/%h exp 3000", F_PC, D_PC); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        NAddr = 32'h3004; tick();
        tests++; if (F_PC !== 32'h3004) begin fails++; $display("FAIL seq1_f_pc got %h exp %h", F_PC, 32'h3004); end
        tests++; if (D_PC !== 32'h3000 || D_Ins !== imem(32'h3000)) begin fails++; $display("FAIL seq1_d got %h/%h exp %h/%h", D_PC, D_Ins, 32'h3000, imem(32'h3000)); end
        NAddr = 32'h3008; tick();
        tests++; if (F_PC !== 32'h3008 || D_PC !== 32'h3004) begin fails++; $display("FAIL seq2 got %h/%h exp 3008/3004", F_PC, D_PC); end
        tests++; if (D_Ins !== imem(32'h3004) || D_ExcCode !== 5'd0) begin fails++; $display("FAIL seq2_d_ins got %h/%h exp %h/0", D_Ins, D_ExcCode, imem(32'h3004)); end
    endtask

    task automatic test_stall();
        NAddr = 32'h300C; tick();
        NAddr = 32'h3010; tick();
        stall = 1'b1; NAddr = 32'h3014;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (F_PC !== 32'h3010 || D_PC !== 32'h300C || D_Ins !== imem(32'h300C)) begin
                fails++; $display("FAIL stall_hold%0d got %h/%h/%h exp 3010/300c/%h", i, F_PC, D_PC, D_Ins, imem(32'h300C));
            end
        end
        stall = 1'b0; tick();
        tests++; if (F_PC !== 32'h3014 || D_PC !== 32'h3010 || D_Ins !== imem(32'h3010)) begin
            fails++; $display("FAIL stall_release got %h/%h/%h exp 3014/3010/%h", F_PC, D_PC, D_Ins, imem(32'h3010));
        end
    endtask

    task automatic test_fetch_fault();
        NAddr = 32'h3002; tick();
        tests++; if (F_PC !== 32'h3002) begin fails++; $display("FAIL misalign_accept got %h exp 3002", F_PC); end
        NAddr = 32'h7000; tick();
        tests++; if (D_PC !== 32'h3002 || D_Ins !== 32'h0 || D_ExcCode !== 5'd4) begin
            fails++; $display("FAIL misalign_d got %h/%h/%h exp 3002/0/4", D_PC, D_Ins, D_ExcCode);
        end
        NAddr = 32'h2FFC; tick();
        tests++; if (D_PC !== 32'h7000 || D_Ins !== 32'h0 || D_ExcCode !== 5'd4) begin
            fails++; $display("FAIL above_hi got %h/%h/%h exp 7000/0/4", D_PC, D_Ins, D_ExcCode);
        end
        NAddr = 32'h6FFC; tick();
        tests++; if (D_PC !== 32'h2FFC || D_Ins !== 32'h0 || D_ExcCode !== 5'd4) begin
            fails++; $display("FAIL below_lo got %h/%h/%h exp 2ffc/0/4", D_PC, D_Ins, D_ExcCode);
        end
        NAddr = 32'hFFFF_FFFC; tick();
        tests++; if (D_PC !== 32'h6FFC || D_Ins !== imem(32'h6FFC) || D_ExcCode !== 5'd0) begin
            fails++; $display("FAIL at_hi got %h/%h/%h exp 6ffc/%h/0", D_PC, D_Ins, D_ExcCode, imem(32'h6FFC));
        end
        tests++; if (F_PCPlus4 !== 32'h0) begin fails++; $display("FAIL pcplus4_wrap got %h exp 0", F_PCPlus4); end
        NAddr = 32'h3000; tick();
        tests++; if (F_PC !== 32'h3000 || D_ExcCode !== 5'd4) begin fails++; $display("FAIL wrap_fault got %h/%h exp 3000/4", F_PC, D_ExcCode); end
        NAddr = 32'h3004; tick();
        tests++; if (D_PC !== 32'h3000 || D_Ins !== imem(32'h3000) || D_ExcCode !== 5'd0) begin
            fails++; $display("FAIL at_lo got %h/%h/%h exp 3000/%h/0", D_PC, D_Ins, D_ExcCode, imem(32'h3000));
        end
    endtask

    task automatic test_req();
        D_IsBranch = 1'b1; stall = 1'b1; req = 1'b1; eret = 1'b1; EPC = 32'h3020; NAddr = 32'h3100;
        tick();
        req = 1'b0; eret = 1'b0; stall = 1'b0; D_IsBranch = 1'b0;
        tests++; if (F_PC !== 32'h4180 || D_PC !== 32'h4180) begin fails++; $display("FAIL req_pc got %h/%h exp 4180/4180", F_PC, D_PC); end
        tests++; if (D_Ins !== 32'h0 || D_ExcCode !== 5'd0 || D_BD !== 1'b0) begin fails++; $display("FAIL req_bubble got %h/%h/%b exp 0/0/0", D_Ins, D_ExcCode, D_BD); end
    endtask

    task automatic test_eret();
        eret = 1'b1; stall = 1'b1; EPC = 32'h3020; D_IsBranch = 1'b1; NAddr = 32'h3100;
        tick();
        eret = 1'b0; stall = 1'b0; D_IsBranch = 1'b0;
        tests++; if (F_PC !== 32'h3020 || D_PC !== 32'h3020) begin fails++; $display("FAIL eret_pc got %h/%h exp 3020/3020", F_PC, D_PC); end
        tests++; if (D_Ins !== 32'h0 || D_BD !== 1'b0) begin fails++; $display("FAIL eret_bubble got %h/%b exp 0/0", D_Ins, D_BD); end
        NAddr = 32'h3024; tick();
        tests++; if (D_PC !== 32'h3020 || D_Ins !== imem(32'h3020) || D_BD !== 1'b0) begin
            fails++; $display("FAIL eret_next got %h/%h/%b exp 3020/%h/0", D_PC, D_Ins, D_BD, imem(32'h3020));
        end
        D_IsBranch = 1'b1; NAddr = 32'h3028; tick();
        tests++; if (D_PC !== 32'h3024 || D_BD !== 1'b1) begin fails++; $display("FAIL delay_slot_bd got %h/%b exp 3024/1", D_PC, D_BD); end
        D_IsBranch = 1'b0; NAddr = 32'h302C; tick();
        tests++; if (D_PC !== 32'h3028 || D_BD !== 1'b0) begin fails++; $display("FAIL bd_clear got %h/%b exp 3028/0", D_PC, D_BD); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1; req = 1'b1; NAddr = 32'h3100;
        #2 reset = 1'b1;
        #1;
        tests++; if (F_PC !== 32'h3000 || D_PC !== 32'h3000) begin fails++; $display("FAIL async_rst_pc got %h/%h exp 3000/3000", F_PC, D_PC); end
        tests++; if ({D_Ins, D_ExcCode, D_BD} !== 38'h0) begin fails++; $display("FAIL async_rst_d got %h/%h/%b exp 0", D_Ins, D_ExcCode, D_BD); end
        tick();
        tests++; if (F_PC !== 32'h3000 || D_PC !== 32'h3000) begin fails++; $display("FAIL rst_override got %h/%h exp 3000/3000", F_PC, D_PC); end
        #2 reset = 1'b0; stall = 1'b0; req = 1'b0; NAddr = 32'h3004;
        tick();
        tests++; if (F_PC !== 32'h3004 || D_PC !== 32'h3000 || D_Ins !== imem(32'h3000)) begin
            fails++; $display("FAIL post_rst_fetch got %h/%h/%h exp 3004/3000/%h", F_PC, D_PC, D_Ins, imem(32'h3000));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_fetch_fault();
        test_req();
        test_eret();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the fetch address after reset.
REQ-002 SHALL have parameter HANDLER_PC, default 32'h0000_4180, meaning the exception/interrupt entry address.
REQ-003 SHALL have parameters IMEM_LO, default 32'h0000_3000, and IMEM_HI, default 32'h0000_6FFC, meaning the legal fetch window (inclusive).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port stall, input, 1 bit: hazard stall; holds PC and the F/D register.
REQ-007 Port req, input, 1 bit: exception/interrupt taken this cycle.
REQ-008 Port eret, input, 1 bit: eret resolved in D this cycle.
REQ-009 Port EPC, input, 32 bits: return address for eret.
REQ-010 Port NAddr, input, 32 bits: next PC from the next-PC logic.
REQ-011 Port D_IsBranch, input, 1 bit: the instruction now in D is a branch/jump, so the instruction in F is a delay slot.
REQ-012 Port i_inst_addr, output, 32 bits: instruction memory address (= F_PC).
REQ-013 Port i_inst_rdata, input, 32 bits: instruction word returned combinationally for i_inst_addr.
REQ-014 Port F_PC, output, 32 bits: current fetch PC.
REQ-015 Port F_PCPlus4, output, 32 bits: F_PC + 4, the sequential address fed to the next-PC logic.
REQ-016 Port D_PC, output, 32 bits: registered PC of the D-stage instruction.
REQ-017 Port D_Ins, output, 32 bits: registered D-stage instruction.
REQ-018 Port D_ExcCode, output, 5 bits: registered fetch exception code (0 = none, 4 = AdEL).
REQ-019 Port D_BD, output, 1 bit: registered branch-delay-slot flag.

Function
REQ-020 F_PCPlus4 SHALL be F_PC + 4, modulo 2^32, combinational.
REQ-021 Fetch fault SHALL be asserted when F_PC[1:0] != 0 or F_PC < IMEM_LO or F_PC > IMEM_HI.
REQ-022 On a fetch fault, the F-stage instruction SHALL be replaced by 32'h0 and its ExcCode SHALL be 4; otherwise the instruction SHALL be i_inst_rdata and the ExcCode 0.
REQ-023 The F-stage BD flag SHALL equal D_IsBranch.
REQ-024 Update priority per cycle SHALL be: req, then eret, then stall, then normal.
REQ-025 On req: PC <= HANDLER_PC; F/D <= {D_PC=HANDLER_PC, D_Ins=0, D_ExcCode=0, D_BD=0}; stall is ignored.
REQ-026 On eret (no req): PC <= EPC; F/D <= {D_PC=EPC, D_Ins=0, D_ExcCode=0, D_BD=0}; stall is ignored.
REQ-027 On stall only: PC and all F/D registers SHALL hold their values.
REQ-028 On normal operation: PC <= NAddr; F/D <= {F_PC, F-stage instruction, F-stage ExcCode, F-stage BD}.
REQ-029 A misaligned or out-of-window NAddr SHALL be accepted into PC unchanged; the fault is flagged only when that address is fetched.
REQ-030 Latency: F to D SHALL be exactly one cycle when no stall is present.

Reset
REQ-031 While reset=1: PC=RESET_PC, D_PC=RESET_PC, D_Ins=0, D_ExcCode=0, D_BD=0, asynchronously and independent of clk.
REQ-032 Reset asserted mid-stall or mid-flush SHALL override all other inputs; the first fetch after deassertion SHALL be from RESET_PC.

Structure
REQ-033 RESET_PC, HANDLER_PC, IMEM_LO/HI and the ExcCode constants (EXC_NONE=0, EXC_ADEL=4) SHALL reside in the shared CPU constants package.
REQ-034 The F/D pipeline register SHALL be a sub-module named f_d_reg, with ports clk, reset, en, flush, flush_pc, and the four data fields.

Verification
REQ-035 Reset release with NAddr=F_PCPlus4 -> F_PC sequence 0x3000, 0x3004, 0x3008; D_PC lags by one cycle.
REQ-036 stall=1 for 2 cycles at F_PC=0x3010 -> F_PC, D_PC and D_Ins are unchanged for those cycles; 0x3014 is fetched after release.
REQ-037 NAddr=0x3002 -> next cycle F-stage ExcCode=4 and instruction=0; one cycle later D_ExcCode=4, D_Ins=0, D_PC=0x3002.
REQ-038 req=1 with stall=1 simultaneously -> F_PC=0x4180, D_PC=0x4180, D_Ins=0; eret=1 in the same cycle is ignored.
REQ-039 eret=1 with EPC=0x3020 -> F_PC=0x3020, D_Ins=0; D_IsBranch=1 while fetching 0x3024 -> D_BD=1 next cycle.
REQ-040 reset pulse asserted between clock edges mid-run -> all outputs return immediately to their REQ-031 values.
